// File: rtl/dram_cmd_pkg.sv
// Shared DRAM command definitions for the issuer and the per-bank timing checker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package dram_cmd_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_REF = 4'd1;
    localparam logic [3:0] CMD_ACT = 4'd2;
    localparam logic [3:0] CMD_RD  = 4'd3;
    localparam logic [3:0] CMD_WR  = 4'd4;
    localparam logic [3:0] CMD_PRE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_GAP
    } issuer_state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic [1:0] bg;
        logic [1:0] bank;
    } dram_req_t;

    // Only REF..PRE may ever be driven onto the checker bus.
    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return (cmd >= CMD_REF) && (cmd <= CMD_PRE);
    endfunction

endpackage

// File: rtl/dram_cmd_issuer_cmd_fifo.sv
// Synchronous request FIFO with full/empty flags, head entry visible combinationally.
// Latency: a push is visible at the head the cycle after the push edge; no bypass.
// Backpressure: pushes are ignored while full, pops are ignored while empty.
module cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer bit separates the full and empty cases when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: nothing is read until a push has written the entry.
    always_ff @(posedge sys_clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dram_cmd_issuer.sv
// Issues queued DRAM commands to the bank timing checker as one-cycle pulses, retrying rejects.
// Latency: request pushed at edge N is issued in cycle N+2, checked in N+3, reported in N+4.
// Backpressure: req_ready drops while the request FIFO is full; the checker stalls via tc_ready.
module dram_cmd_issuer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int RETRY_GAP    = 2,
    parameter int MAX_ATTEMPTS = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [1:0]  req_bank_group,
    input  logic [1:0]  req_bank,
    output logic [3:0]  cmd_decoded,
    output logic [1:0]  bank_group,
    output logic [1:0]  bank,
    input  logic        tc_ready,
    output logic        done_valid,
    output logic        err_valid,
    output logic [3:0]  done_cmd,
    output logic        busy,
    output logic [15:0] retry_cnt
);

    import dram_cmd_pkg::*;

    localparam logic [7:0] GAP_LAST = (RETRY_GAP > 0) ? 8'(RETRY_GAP - 1) : 8'd0;
    localparam logic [7:0] ATT_MAX  = 8'(MAX_ATTEMPTS);

    issuer_state_t state, nxt;
    dram_req_t     head;
    dram_req_t     push_req;
    logic          full, empty;
    logic          pop, done_nxt, err_nxt, reject;
    logic [7:0]    attempt_cnt;
    logic [7:0]    gap_cnt;

    assign push_req  = '{cmd: req_cmd, bg: req_bank_group, bank: req_bank};
    assign req_ready = !full;
    assign busy      = (state != ST_IDLE) || !empty;

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      ($bits(dram_req_t))
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (req_valid),
        .push_dat  (push_req),
        .pop       (pop),
        .head_dat  (head),
        .full      (full),
        .empty     (empty)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= nxt;
    end

    // Next state, pop and report decisions; tc_ready only matters in CHECK.
    always_comb begin
        nxt      = state;
        pop      = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        reject   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    if (cmd_is_valid(head.cmd)) begin
                        nxt = ST_ISSUE;
                    end else begin
                        pop     = 1'b1;
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: nxt = ST_CHECK;
            ST_CHECK: begin
                // The checker never grants REF, so REF counts as accepted on issue.
                if ((head.cmd == CMD_REF) || tc_ready) begin
                    pop      = 1'b1;
                    done_nxt = 1'b1;
                    nxt      = ST_IDLE;
                end else begin
                    reject = 1'b1;
                    if (attempt_cnt == ATT_MAX) begin
                        pop     = 1'b1;
                        err_nxt = 1'b1;
                        nxt     = ST_IDLE;
                    end else if (RETRY_GAP == 0) begin
                        nxt = ST_ISSUE;
                    end else begin
                        nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) nxt = ST_ISSUE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Registered checker bus and report pulses; the bus carries a command only while in ISSUE.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_decoded <= CMD_NOP;
            bank_group  <= '0;
            bank        <= '0;
            done_valid  <= 1'b0;
            err_valid   <= 1'b0;
            done_cmd    <= '0;
        end else begin
            cmd_decoded <= (nxt == ST_ISSUE) ? head.cmd : CMD_NOP;
            if (nxt == ST_ISSUE) begin
                bank_group <= head.bg;
                bank       <= head.bank;
            end
            done_valid <= done_nxt;
            err_valid  <= err_nxt;
            if (done_nxt || err_nxt) done_cmd <= head.cmd;
        end
    end

    // Attempt, NOP-gap and saturating retry counters.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            attempt_cnt <= '0;
            gap_cnt     <= '0;
            retry_cnt   <= '0;
        end else begin
            if ((state == ST_IDLE) && (nxt == ST_ISSUE)) attempt_cnt <= '0;
            else if (state == ST_ISSUE)                  attempt_cnt <= attempt_cnt + 8'd1;
            if (state == ST_GAP) gap_cnt <= gap_cnt + 8'd1;
            else                 gap_cnt <= '0;
            if (reject && (retry_cnt != 16'hFFFF)) retry_cnt <= retry_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench for dram_cmd_issuer with a behavioural per-bank checker model.
// A default instance (RETRY_GAP=2, MAX_ATTEMPTS=255) and a MAX_ATTEMPTS=3 instance share inputs.
// Vectors run from reset; cycle 0 is the cycle the first request is driven.
module tb_dram_cmd_issuer;
    import dram_cmd_pkg::*;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        req_valid;
    logic [3:0]  req_cmd;
    logic [1:0]  req_bank_group;
    logic [1:0]  req_bank;

    logic        req_ready, tc_ready, done_valid, err_valid, busy;
    logic [3:0]  cmd_decoded, done_cmd;
    logic [1:0]  bank_group, bank;
    logic [15:0] retry_cnt;

    logic        req_ready_m, tc_ready_m, done_valid_m, err_valid_m, busy_m;
    logic [3:0]  cmd_decoded_m, done_cmd_m;
    logic [1:0]  bank_group_m, bank_m;
    logic [15:0] retry_cnt_m;

    dram_cmd_issuer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_bank_group(req_bank_group), .req_bank(req_bank),
        .cmd_decoded(cmd_decoded), .bank_group(bank_group), .bank(bank), .tc_ready(tc_ready),
        .done_valid(done_valid), .err_valid(err_valid), .done_cmd(done_cmd), .busy(busy),
        .retry_cnt(retry_cnt)
    );

    dram_cmd_issuer #(.MAX_ATTEMPTS(3)) dut_m (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_ready(req_ready_m),
        .req_cmd(req_cmd), .req_bank_group(req_bank_group), .req_bank(req_bank),
        .cmd_decoded(cmd_decoded_m), .bank_group(bank_group_m), .bank(bank_m), .tc_ready(tc_ready_m),
        .done_valid(done_valid_m), .err_valid(err_valid_m), .done_cmd(done_cmd_m), .busy(busy_m),
        .retry_cnt(retry_cnt_m)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Checker model: per-bank NOP countdown timers, registered grant, REF never granted.
    logic [3:0] mcmd [2];
    logic [3:0] midx [2];
    logic       rdy  [2];
    logic [5:0] tmr  [2][16];

    assign mcmd[0] = cmd_decoded;
    assign mcmd[1] = cmd_decoded_m;
    assign midx[0] = {bank_group, bank};
    assign midx[1] = {bank_group_m, bank_m};
    assign tc_ready   = rdy[0];
    assign tc_ready_m = rdy[1];

    function automatic logic [5:0] t_of(input logic [3:0] c);
        case (c)
            CMD_REF: return 6'd50;
            CMD_ACT: return 6'd18;
            CMD_RD:  return 6'd32;
            CMD_WR:  return 6'd20;
            CMD_PRE: return 6'd18;
            default: return 6'd0;
        endcase
    endfunction

    always @(posedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!sys_rst_n) begin
                rdy[k] <= 1'b0;
                for (int i = 0; i < 16; i++) tmr[k][i] <= 6'd0;
            end else if (mcmd[k] == CMD_REF) begin
                rdy[k] <= 1'b0;
                for (int i = 0; i < 16; i++) tmr[k][i] <= 6'd50;
            end else if (mcmd[k] != CMD_NOP) begin
                if (tmr[k][midx[k]] == 6'd0) begin
                    rdy[k] <= 1'b1;
                    tmr[k][midx[k]] <= t_of(mcmd[k]);
                end else begin
                    rdy[k] <= 1'b0;
                end
            end else begin
                for (int i = 0; i < 16; i++)
                    if (tmr[k][i] != 6'd0) tmr[k][i] <= tmr[k][i] - 6'd1;
            end
        end
    end

    // Watch for command pulses on two consecutive cycles at either instance.
    int  b2b_viol = 0;
    logic prev_nz = 1'b0, prev_nz_m = 1'b0;
    always @(negedge sys_clk) begin
        if (prev_nz && (cmd_decoded != CMD_NOP)) b2b_viol++;
        if (prev_nz_m && (cmd_decoded_m != CMD_NOP)) b2b_viol++;
        prev_nz   <= (cmd_decoded != CMD_NOP);
        prev_nz_m <= (cmd_decoded_m != CMD_NOP);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    task automatic drive(input int c, input int g, input int b);
        req_valid      = 1'b1;
        req_cmd        = 4'(c);
        req_bank_group = 2'(g);
        req_bank       = 2'(b);
    endtask

    // kind: 1 = done, 2 = err; iss_at = cycle of the first command pulse (-1 if none)
    typedef struct {
        int n;
        int c0, g0, b0;
        int c1, g1, b1;
        int kind, dcmd, issues, retry, lat, iss_at;
    } vec_t;

    vec_t vt [8];

    initial begin
        int pulses, issues, first_lat, first_iss, last_kind, last_cmd, errs_m;
        sys_rst_n = 1'b0; req_valid = 1'b0;
        req_cmd = '0; req_bank_group = '0; req_bank = '0;

        //        n  c0 g0 b0  c1 g1 b1  kind dcmd iss ret lat iss_at
        vt[0] = '{1, 2, 0, 1,  0, 0, 0,  1,   2,   1,  0,  4,  2};
        vt[1] = '{2, 2, 1, 0,  3, 1, 0,  1,   3,   8,  6,  4,  2};
        vt[2] = '{1, 7, 0, 0,  0, 0, 0,  2,   7,   0,  0,  2, -1};
        vt[3] = '{2, 2, 0, 0,  1, 0, 0,  1,   1,   2,  0,  4,  2};
        vt[4] = '{1, 4, 2, 3,  0, 0, 0,  1,   4,   1,  0,  4,  2};
        vt[5] = '{2, 5, 3, 3,  0, 0, 0,  2,   0,   1,  0,  4,  2};
        vt[6] = '{2, 3, 0, 0,  3, 0, 0,  1,   3,  12, 10,  4,  2};
        vt[7] = '{2, 1, 0, 0,  2, 3, 2,  1,   2,  18, 16,  4,  2};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            pulses = 0; issues = 0; first_lat = -1; first_iss = -1; last_kind = 0; last_cmd = -1;
            drive(vt[v].c0, vt[v].g0, vt[v].b0);
            for (int t = 0; t < 400 && pulses < vt[v].n; t++) begin
                @(negedge sys_clk);
                if (cmd_decoded != CMD_NOP) begin
                    issues++;
                    if (first_iss < 0) first_iss = t;
                end
                if (done_valid || err_valid) begin
                    pulses++;
                    if (first_lat < 0) first_lat = t;
                    last_kind = done_valid ? 1 : 2;
                    last_cmd  = int'(done_cmd);
                end
                step();
                if (t == 0 && vt[v].n == 2) drive(vt[v].c1, vt[v].g1, vt[v].b1);
                else                        req_valid = 1'b0;
            end
            check($sformatf("v%0d pulse_count", v), pulses, vt[v].n);
            check($sformatf("v%0d final_kind", v), last_kind, vt[v].kind);
            check($sformatf("v%0d done_cmd", v), last_cmd, vt[v].dcmd);
            check($sformatf("v%0d issues", v), issues, vt[v].issues);
            check($sformatf("v%0d retry_cnt", v), int'(retry_cnt), vt[v].retry);
            check($sformatf("v%0d first_pulse_cycle", v), first_lat, vt[v].lat);
            check($sformatf("v%0d first_issue_cycle", v), first_iss, vt[v].iss_at);
        end

        // Reset after the last vector left bank_group=3, bank=2, done_cmd=2, retry_cnt=16.
        do_reset();
        @(negedge sys_clk);
        check("rst cmd_decoded", int'(cmd_decoded), 0);
        check("rst bank_group", int'(bank_group), 0);
        check("rst bank", int'(bank), 0);
        check("rst done_valid", int'(done_valid), 0);
        check("rst err_valid", int'(err_valid), 0);
        check("rst done_cmd", int'(done_cmd), 0);
        check("rst busy", int'(busy), 0);
        check("rst retry_cnt", int'(retry_cnt), 0);
        check("rst req_ready", int'(req_ready), 1);

        // MAX_ATTEMPTS=3: WR right after REF is tried three times and aborted in cycle 15.
        step();
        do_reset();
        pulses = 0; issues = 0; last_kind = 0; last_cmd = -1; first_lat = -1;
        drive(CMD_REF, 0, 0);
        for (int t = 0; t < 400 && pulses < 2; t++) begin
            @(negedge sys_clk);
            if (cmd_decoded_m != CMD_NOP) issues++;
            if (done_valid_m || err_valid_m) begin
                pulses++;
                last_kind = done_valid_m ? 1 : 2;
                last_cmd  = int'(done_cmd_m);
                first_lat = t;
            end
            step();
            if (t == 0) drive(CMD_WR, 1, 2);
            else        req_valid = 1'b0;
        end
        check("max pulse_count", pulses, 2);
        check("max final_kind", last_kind, 2);
        check("max done_cmd", last_cmd, 4);
        check("max issues", issues, 4);
        check("max retry_cnt", int'(retry_cnt_m), 3);
        check("max err_cycle", first_lat, 15);

        // Fill the FIFO with ACT bg0/b0, then reset while the second ACT is re-issued in cycle 9.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drive(CMD_ACT, 0, 0);
            @(negedge sys_clk);
            check($sformatf("fill req_ready c%0d", t), int'(req_ready), 1);
            step();
        end
        req_valid = 1'b0;
        @(negedge sys_clk);
        check("full req_ready c5", int'(req_ready), 0);
        for (int t = 5; t < 9; t++) step();
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("pre-reset cmd_decoded c9", int'(cmd_decoded), int'(CMD_ACT));
        step();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("post-reset cmd_decoded", int'(cmd_decoded), 0);
        check("post-reset busy", int'(busy), 0);
        check("post-reset req_ready", int'(req_ready), 1);
        check("post-reset retry_cnt", int'(retry_cnt), 0);
        pulses = 0; issues = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            @(negedge sys_clk);
            if (done_valid || err_valid) pulses++;
            if (cmd_decoded != CMD_NOP) issues++;
        end
        check("post-reset pulses", pulses, 0);
        check("post-reset issues", issues, 0);
        check("post-reset busy idle", int'(busy), 0);

        check("back_to_back_cmds", b2b_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
